// File: rtl/fpga_test_pkg.sv
// Shared types and helpers for the self-check UART reporter: event kinds,
// formatter states, ASCII constants, nibble-to-hex conversion and line lengths.
package fpga_test_pkg;

    typedef enum logic [1:0] {
        EV_TEST_OK  = 2'd0,
        EV_ALL_PASS = 2'd1,
        EV_FAIL     = 2'd2,
        EV_RSVD     = 2'd3
    } ev_kind_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_WAIT = 2'd3
    } fmt_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_EQ = 8'h3D;

    localparam int TEST_OK_LEN    = 7;
    localparam int ALL_PASS_LEN   = 9;
    localparam int FAIL_FIXED_LEN = 15;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

    function automatic int fail_line_len(input int dlen);
        return 2 * (dlen / 4) + FAIL_FIXED_LEN;
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, one stop bit,
// each DIV clocks long; tx_done is high during the last clock of the stop bit.
module uart_tx_8n1 #(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_done
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_TOP = CW'(DIV - 1);

    logic          active_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [8:0]    shf_q;
    logic          tx_q;

    assign tx      = tx_q;
    assign tx_done = active_q && (cnt_q == {CW{1'b0}}) && (bit_q == 4'd9);

    // Baud and bit counters; shf_q holds the bits still to go out, stop bit on top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            bit_q    <= 4'd0;
            shf_q    <= 9'h1FF;
            tx_q     <= 1'b1;
        end else if (tx_start) begin
            active_q <= 1'b1;
            cnt_q    <= CNT_TOP;
            bit_q    <= 4'd0;
            shf_q    <= {1'b1, tx_data};
            tx_q     <= 1'b0;
        end else if (active_q) begin
            if (cnt_q != {CW{1'b0}}) begin
                cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end else if (bit_q == 4'd9) begin
                active_q <= 1'b0;
                tx_q     <= 1'b1;
            end else begin
                tx_q  <= shf_q[0];
                shf_q <= {1'b1, shf_q[8:1]};
                bit_q <= bit_q + 4'd1;
                cnt_q <= CNT_TOP;
            end
        end else begin
            tx_q <= 1'b1;
        end
    end

endmodule

// File: rtl/fpga_test_uart_reporter.sv
// Formats self-check sequencer events as ASCII report lines and sends them
// over an 8N1 UART, one event in flight, back-pressuring via ev_ready.
module fpga_test_uart_reporter
    import fpga_test_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200,
    parameter int DLEN   = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ev_valid,
    output logic            ev_ready,
    input  logic [1:0]      ev_kind,
    input  logic [3:0]      ev_test,
    input  logic [7:0]      ev_passed,
    input  logic [DLEN-1:0] ev_result,
    input  logic [DLEN-1:0] ev_golden,
    output logic            uart_tx,
    output logic            busy
);
    localparam int DIV      = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int NIB      = DLEN / 4;
    localparam int LINE_MAX = fail_line_len(DLEN);
    localparam int IW       = $clog2(LINE_MAX);

    // Character positions inside a FAIL line.
    localparam logic [IW-1:0] R_FIRST = IW'(10);
    localparam logic [IW-1:0] E_SEP   = IW'(10 + NIB);
    localparam logic [IW-1:0] E_LBL   = IW'(11 + NIB);
    localparam logic [IW-1:0] E_FIRST = IW'(13 + NIB);
    localparam logic [IW-1:0] CR_IDX  = IW'(13 + 2 * NIB);

    fmt_state_e      state_q, state_d;
    ev_kind_e        kind_q;
    logic [3:0]      test_q;
    logic [7:0]      passed_q;
    logic [DLEN-1:0] res_q;
    logic [DLEN-1:0] gold_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   last_q;
    logic [7:0]      char_q;
    logic [7:0]      char_d;
    logic            busy_q;
    logic            ready_q;
    logic            accept_s;
    logic            tx_start_s;
    logic            tx_done_s;
    logic            shift_res_s;
    logic            shift_gold_s;

    assign accept_s = ev_valid && ready_q;
    assign ev_ready = ready_q;
    assign busy     = busy_q;

    // Formatter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; reserved events are consumed without leaving IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && (ev_kind != EV_RSVD)) state_d = S_LOAD;
                else                                  state_d = S_IDLE;
            end
            S_LOAD: state_d = S_SEND;
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done_s) state_d = (idx_q == last_q) ? S_IDLE : S_LOAD;
                else           state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded controls.
    always_comb begin
        tx_start_s   = (state_q == S_SEND);
        shift_res_s  = (state_q == S_LOAD) && (kind_q == EV_FAIL) &&
                       (idx_q >= R_FIRST) && (idx_q < E_SEP);
        shift_gold_s = (state_q == S_LOAD) && (kind_q == EV_FAIL) &&
                       (idx_q >= E_FIRST) && (idx_q < CR_IDX);
    end

    // Character for the current position; R/E digits come from the MS nibble of shifting copies.
    always_comb begin
        char_d = ASCII_LF;
        case (kind_q)
            EV_TEST_OK: begin
                case (idx_q)
                    IW'(0):  char_d = 8'h54;               // T
                    IW'(1):  char_d = hex_ascii(test_q);
                    IW'(2):  char_d = ASCII_SP;
                    IW'(3):  char_d = 8'h4F;               // O
                    IW'(4):  char_d = 8'h4B;               // K
                    IW'(5):  char_d = ASCII_CR;
                    default: char_d = ASCII_LF;
                endcase
            end
            EV_ALL_PASS: begin
                case (idx_q)
                    IW'(0):  char_d = 8'h50;               // P
                    IW'(1):  char_d = 8'h41;               // A
                    IW'(2):  char_d = 8'h53;               // S
                    IW'(3):  char_d = 8'h53;               // S
                    IW'(4):  char_d = ASCII_SP;
                    IW'(5):  char_d = hex_ascii(passed_q[7:4]);
                    IW'(6):  char_d = hex_ascii(passed_q[3:0]);
                    IW'(7):  char_d = ASCII_CR;
                    default: char_d = ASCII_LF;
                endcase
            end
            EV_FAIL: begin
                if (idx_q < R_FIRST) begin
                    case (idx_q)
                        IW'(0):  char_d = 8'h46;           // F
                        IW'(1):  char_d = 8'h41;           // A
                        IW'(2):  char_d = 8'h49;           // I
                        IW'(3):  char_d = 8'h4C;           // L
                        IW'(4):  char_d = ASCII_SP;
                        IW'(5):  char_d = 8'h54;           // T
                        IW'(6):  char_d = hex_ascii(test_q);
                        IW'(7):  char_d = ASCII_SP;
                        IW'(8):  char_d = 8'h52;           // R
                        default: char_d = ASCII_EQ;
                    endcase
                end else if (idx_q < E_SEP) begin
                    char_d = hex_ascii(res_q[DLEN-1 -: 4]);
                end else if (idx_q == E_SEP) begin
                    char_d = ASCII_SP;
                end else if (idx_q == E_LBL) begin
                    char_d = 8'h45;                        // E
                end else if (idx_q < E_FIRST) begin
                    char_d = ASCII_EQ;
                end else if (idx_q < CR_IDX) begin
                    char_d = hex_ascii(gold_q[DLEN-1 -: 4]);
                end else if (idx_q == CR_IDX) begin
                    char_d = ASCII_CR;
                end else begin
                    char_d = ASCII_LF;
                end
            end
            default: char_d = ASCII_LF;
        endcase
    end

    // Field latches, char index, outgoing character and handshake/busy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q   <= EV_TEST_OK;
            test_q   <= 4'd0;
            passed_q <= 8'd0;
            res_q    <= {DLEN{1'b0}};
            gold_q   <= {DLEN{1'b0}};
            idx_q    <= {IW{1'b0}};
            last_q   <= {IW{1'b0}};
            char_q   <= 8'd0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            busy_q  <= (state_d != S_IDLE);
            ready_q <= (state_d == S_IDLE);
            if (accept_s) begin
                kind_q   <= ev_kind_e'(ev_kind);
                test_q   <= ev_test;
                passed_q <= ev_passed;
                res_q    <= ev_result;
                gold_q   <= ev_golden;
                idx_q    <= {IW{1'b0}};
                case (ev_kind_e'(ev_kind))
                    EV_TEST_OK:  last_q <= IW'(TEST_OK_LEN - 1);
                    EV_ALL_PASS: last_q <= IW'(ALL_PASS_LEN - 1);
                    default:     last_q <= IW'(LINE_MAX - 1);
                endcase
            end else begin
                if (shift_res_s)  res_q  <= {res_q[DLEN-5:0], 4'h0};
                if (shift_gold_s) gold_q <= {gold_q[DLEN-5:0], 4'h0};
                if ((state_q == S_WAIT) && tx_done_s && (idx_q != last_q)) begin
                    idx_q <= idx_q + {{(IW-1){1'b0}}, 1'b1};
                end
            end
            if (state_q == S_LOAD) char_q <= char_d;
        end
    end

    uart_tx_8n1 #(
        .DIV(DIV)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_start(tx_start_s),
        .tx_data (char_q),
        .tx      (uart_tx),
        .tx_done (tx_done_s)
    );

endmodule

// File: tb/tb_fpga_test_uart_reporter.sv
// Bench for the UART reporter: drives sequencer events, decodes the serial line
// at DIV clocks per bit and compares against text lines built from the event fields.
module tb_fpga_test_uart_reporter;
    localparam int DIV  = 10;
    localparam int DLEN = 32;
    localparam int NIB  = DLEN / 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ev_valid = 1'b0;
    logic [1:0]      ev_kind = 2'd0;
    logic [3:0]      ev_test = 4'd0;
    logic [7:0]      ev_passed = 8'd0;
    logic [DLEN-1:0] ev_result = '0;
    logic [DLEN-1:0] ev_golden = '0;
    logic            ev_ready;
    logic            uart_tx;
    logic            busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    string      rx_line = "";
    int         mon_pos = -1;

    always #5 clk = ~clk;

    fpga_test_uart_reporter #(
        .CLK_HZ(1_000_000),
        .BAUD  (100_000),
        .DLEN  (DLEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_kind  (ev_kind),
        .ev_test  (ev_test),
        .ev_passed(ev_passed),
        .ev_result(ev_result),
        .ev_golden(ev_golden),
        .uart_tx  (uart_tx),
        .busy     (busy)
    );

    function automatic void chk(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void chk_s(input string name, input string act, input string req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=\"%s\" required=\"%s\"", name, act, req);
        end
    endfunction

    function automatic string hexd(input int n);
        string hx = "0123456789ABCDEF";
        return hx.substr(n, n);
    endfunction

    // Reference text of a report line.
    function automatic string fmt_line(input logic [1:0] k, input logic [3:0] t, input logic [7:0] p,
                                       input logic [DLEN-1:0] r, input logic [DLEN-1:0] g);
        string s;
        case (k)
            2'd0: s = {"T", hexd(int'(t)), " OK\r\n"};
            2'd1: s = {"PASS ", hexd(int'(p[7:4])), hexd(int'(p[3:0])), "\r\n"};
            2'd2: begin
                s = {"FAIL T", hexd(int'(t)), " R="};
                for (int i = NIB - 1; i >= 0; i--) s = {s, hexd(int'((r >> (4 * i)) & 32'hF))};
                s = {s, " E="};
                for (int i = NIB - 1; i >= 0; i--) s = {s, hexd(int'((g >> (4 * i)) & 32'hF))};
                s = {s, "\r\n"};
            end
            default: s = "";
        endcase
        return s;
    endfunction

    // Serial monitor: frames, per-bit stability, inter-char gap, busy window.
    logic [7:0] mbyte;
    logic       bref;
    bit         glitch, busylow, gap_armed, end_chk;
    int         gap;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_pos   = -1;
            gap_armed = 1'b0;
            end_chk   = 1'b0;
        end else begin
            if (end_chk) begin
                chk("busy_fall_ready_rise", (busy == 1'b0) && (ev_ready == 1'b1), {busy, ev_ready}, 2'b01);
                end_chk = 1'b0;
            end
            if (mon_pos < 0) begin
                if (uart_tx == 1'b0) begin
                    if (gap_armed) chk("char_gap", gap <= 3, gap, 3);
                    gap_armed = 1'b0;
                    mon_pos   = 0;
                    glitch    = 1'b0;
                    busylow   = 1'b0;
                end else begin
                    gap++;
                end
            end
            if (mon_pos >= 0) begin
                if (mon_pos % DIV == 0) bref = uart_tx;
                else if (uart_tx !== bref) glitch = 1'b1;
                if ((mon_pos % DIV == 0) && (mon_pos / DIV >= 1) && (mon_pos / DIV <= 8))
                    mbyte[mon_pos / DIV - 1] = uart_tx;
                if (!busy) busylow = 1'b1;
                mon_pos++;
                if (mon_pos == 10 * DIV) begin
                    chk("frame", !glitch && (bref == 1'b1), {glitch, bref}, 1);
                    chk("busy_during_char", !busylow, busylow, 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_char", 1'b0, mbyte, 0);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        chk("char", mbyte == e, mbyte, e);
                    end
                    rx_line   = {rx_line, $sformatf("%c", mbyte)};
                    gap       = 0;
                    gap_armed = (exp_q.size() != 0);
                    end_chk   = (exp_q.size() == 0);
                    mon_pos   = -1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx", uart_tx == 1'b1, uart_tx, 1);
        chk("rst_busy", busy == 1'b0, busy, 0);
        chk("rst_ready", ev_ready == 1'b0, ev_ready, 0);
        exp_q.delete();
        rx_line = "";
        repeat (4) @(negedge clk);
        chk("rst_tx_held", uart_tx == 1'b1, uart_tx, 1);
        #2 rst_n = 1'b1;
        #1 chk("ready_first_cycle", ev_ready == 1'b0, ev_ready, 0);
        @(negedge clk);
        chk("ready_second_cycle", ev_ready == 1'b1, ev_ready, 1);
    endtask

    task automatic send(input logic [1:0] k, input logic [3:0] t, input logic [7:0] p,
                        input logic [DLEN-1:0] r, input logic [DLEN-1:0] g, input bit hold_chk);
        string s;
        int    n;
        bit    seen;
        @(negedge clk);
        ev_kind = k; ev_test = t; ev_passed = p; ev_result = r; ev_golden = g;
        ev_valid = 1'b1;
        n = 0;
        while (!ev_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", ev_ready == 1'b1, n, 5000);
        if (hold_chk) chk("held_until_line_end", (exp_q.size() == 0) && (mon_pos < 0), exp_q.size(), 0);
        s = fmt_line(k, t, p, r, g);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(negedge clk);
        if (k == 2'd3) begin
            chk("rsvd_consumed", (ev_ready == 1'b1) && (busy == 1'b0), {ev_ready, busy}, 2'b10);
            seen = 1'b0;
            repeat (30) begin
                if (!uart_tx) seen = 1'b1;
                @(negedge clk);
            end
            chk("rsvd_quiet", !seen, seen, 0);
        end else begin
            chk("busy_rise", busy == 1'b1, busy, 1);
            seen = (uart_tx == 1'b0);
            n = 1;
            while (!seen && n < 4) begin
                @(negedge clk);
                n++;
                seen = (uart_tx == 1'b0);
            end
            chk("start_latency", seen, n, 4);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!((exp_q.size() == 0) && (mon_pos < 0) && (busy == 1'b0)) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("line_timeout", n < 6000, n, 6000);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit tx_low, busy_hi, rdy_lo;
        int n;
        logic [1:0] k;
        logic [3:0] t;
        logic [7:0] p;
        logic [DLEN-1:0] r, g;

        // Reset and long idle period.
        do_reset();
        tx_low = 1'b0; busy_hi = 1'b0; rdy_lo = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (!uart_tx) tx_low = 1'b1;
            if (busy) busy_hi = 1'b1;
            if (!ev_ready) rdy_lo = 1'b1;
        end
        chk("idle_tx_high", !tx_low, tx_low, 0);
        chk("idle_busy_low", !busy_hi, busy_hi, 0);
        chk("idle_ready_high", !rdy_lo, rdy_lo, 0);

        chk_s("model_pin_fail", fmt_line(2'd2, 4'd9, 8'd0, 32'h0000_00FF, 32'h0000_0100),
              "FAIL T9 R=000000FF E=00000100\r\n");

        rx_line = "";
        send(2'd0, 4'd3, 8'd0, '0, '0, 1'b0);
        wait_done();
        chk_s("line_test_ok", rx_line, "T3 OK\r\n");

        rx_line = "";
        send(2'd2, 4'd9, 8'd0, 32'h0000_00FF, 32'h0000_0100, 1'b0);
        wait_done();
        chk_s("line_fail", rx_line, "FAIL T9 R=000000FF E=00000100\r\n");

        // Second event offered while the first line is still going out.
        rx_line = "";
        send(2'd1, 4'd0, 8'h0A, '0, '0, 1'b0);
        send(2'd0, 4'hC, 8'd0, '0, '0, 1'b1);
        wait_done();
        chk_s("line_pass_then_ok", rx_line, "PASS 0A\r\nTC OK\r\n");

        // Reset in the middle of a FAIL line.
        rx_line = "";
        send(2'd2, 4'd5, 8'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        n = 0;
        while (!((rx_line.len() == 12) && (mon_pos >= 2 * DIV)) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_char12", n < 5000, n, 5000);
        do_reset();
        repeat (200) @(negedge clk);
        chk_s("no_resume", rx_line, "");
        send(2'd0, 4'd0, 8'd0, '0, '0, 1'b0);
        wait_done();
        chk_s("line_after_reset", rx_line, "T0 OK\r\n");

        // Reserved kind, then a normal event.
        rx_line = "";
        send(2'd3, 4'd7, 8'h55, 32'hFFFF_FFFF, 32'h0, 1'b0);
        send(2'd0, 4'hF, 8'd0, '0, '0, 1'b0);
        wait_done();
        chk_s("line_after_rsvd", rx_line, "TF OK\r\n");

        // Randomized events against the text model.
        for (int i = 0; i < 8; i++) begin
            k = 2'($urandom_range(0, 3));
            t = 4'($urandom);
            p = 8'($urandom);
            r = DLEN'($urandom);
            g = DLEN'($urandom);
            rx_line = "";
            send(k, t, p, r, g, 1'b0);
            wait_done();
            chk_s("rand_line", rx_line, fmt_line(k, t, p, r, g));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
